// File: rtl/id_ex_hazard_reg.sv
// id_ex_hazard_reg: ID/EX pipeline register with load-use hazard detection and a stall counter
// Ports:
//   clk, rst_n             - clock and asynchronous active-low reset
//   valid_id, *_id         - decoded instruction presented by the ID stage
//   flush                  - taken branch/jump in EX; the ID instruction is killed
//   valid_ex, *_ex         - registered EX-stage copy of the instruction
//   stall                  - hold PC and IF/ID this cycle (load-use hazard)
//   stall_cnt              - saturating count of stall cycles
module id_ex_hazard_reg #(
    parameter int XLEN = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_id,
    input  logic [4:0]      rs1Addr_id,
    input  logic [4:0]      rs2Addr_id,
    input  logic [4:0]      rdAddr_id,
    input  logic            rs1Used_id,
    input  logic            rs2Used_id,
    input  logic [XLEN-1:0] rs1Data_id,
    input  logic [XLEN-1:0] rs2Data_id,
    input  logic [XLEN-1:0] imm_id,
    input  logic [XLEN-1:0] pc_id,
    input  logic            RegWrite_id,
    input  logic            MemRead_id,
    input  logic            MemWrite_id,
    input  logic            MemtoReg_id,
    input  logic            ALUSrc_id,
    input  logic [3:0]      ALUOp_id,
    input  logic            flush,
    output logic            valid_ex,
    output logic [4:0]      rs1Addr_ex,
    output logic [4:0]      rs2Addr_ex,
    output logic [4:0]      rdAddr_ex,
    output logic [XLEN-1:0] rs1Data_ex,
    output logic [XLEN-1:0] rs2Data_ex,
    output logic [XLEN-1:0] imm_ex,
    output logic [XLEN-1:0] pc_ex,
    output logic            RegWrite_ex,
    output logic            MemRead_ex,
    output logic            MemWrite_ex,
    output logic            MemtoReg_ex,
    output logic            ALUSrc_ex,
    output logic [3:0]      ALUOp_ex,
    output logic            stall,
    output logic [CNTW-1:0] stall_cnt
);
    logic hazard;
    logic capture;
    // A load in EX whose destination is read by the ID instruction; x0 is never a real dependency.
    always_comb begin
        hazard  = valid_ex & MemRead_ex & (rdAddr_ex != 5'd0) &
                  ((rs1Used_id & (rdAddr_ex == rs1Addr_id)) | (rs2Used_id & (rdAddr_ex == rs2Addr_id)));
        stall   = valid_id & ~flush & hazard;
        capture = valid_id & ~flush & ~hazard;
    end
    // Any non-captured cycle loads an all-zero bubble, so rd=0/RegWrite=0/MemRead=0 in EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_ex    <= 1'b0;
            rs1Addr_ex  <= '0;
            rs2Addr_ex  <= '0;
            rdAddr_ex   <= '0;
            rs1Data_ex  <= '0;
            rs2Data_ex  <= '0;
            imm_ex      <= '0;
            pc_ex       <= '0;
            RegWrite_ex <= 1'b0;
            MemRead_ex  <= 1'b0;
            MemWrite_ex <= 1'b0;
            MemtoReg_ex <= 1'b0;
            ALUSrc_ex   <= 1'b0;
            ALUOp_ex    <= '0;
            stall_cnt   <= '0;
        end else begin
            valid_ex    <= capture;
            rs1Addr_ex  <= capture ? rs1Addr_id  : '0;
            rs2Addr_ex  <= capture ? rs2Addr_id  : '0;
            rdAddr_ex   <= capture ? rdAddr_id   : '0;
            rs1Data_ex  <= capture ? rs1Data_id  : '0;
            rs2Data_ex  <= capture ? rs2Data_id  : '0;
            imm_ex      <= capture ? imm_id      : '0;
            pc_ex       <= capture ? pc_id       : '0;
            RegWrite_ex <= capture & RegWrite_id;
            MemRead_ex  <= capture & MemRead_id;
            MemWrite_ex <= capture & MemWrite_id;
            MemtoReg_ex <= capture & MemtoReg_id;
            ALUSrc_ex   <= capture & ALUSrc_id;
            ALUOp_ex    <= capture ? ALUOp_id    : '0;
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// tb_id_ex_hazard_reg: scoreboard bench for id_ex_hazard_reg against a behavioural pipeline model
module tb_id_ex_hazard_reg;
    localparam int XLEN = 32;
    localparam int CNTW = 4;

    typedef struct packed {
        logic            v;
        logic [4:0]      rs1, rs2, rd;
        logic            u1, u2;
        logic [XLEN-1:0] d1, d2, imm, pc;
        logic            rw, mr, mw, m2r, as;
        logic [3:0]      op;
    } instr_t;

    typedef struct packed {
        instr_t          ex;
        logic            stall;
        logic [CNTW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    instr_t cur = '0;
    logic curFlush = 1'b0;

    logic valid_ex, RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, ALUSrc_ex, stall;
    logic [4:0] rs1Addr_ex, rs2Addr_ex, rdAddr_ex;
    logic [XLEN-1:0] rs1Data_ex, rs2Data_ex, imm_ex, pc_ex;
    logic [3:0] ALUOp_ex;
    logic [CNTW-1:0] stall_cnt;

    id_ex_hazard_reg #(.XLEN(XLEN), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_id(cur.v), .rs1Addr_id(cur.rs1), .rs2Addr_id(cur.rs2), .rdAddr_id(cur.rd),
        .rs1Used_id(cur.u1), .rs2Used_id(cur.u2),
        .rs1Data_id(cur.d1), .rs2Data_id(cur.d2), .imm_id(cur.imm), .pc_id(cur.pc),
        .RegWrite_id(cur.rw), .MemRead_id(cur.mr), .MemWrite_id(cur.mw),
        .MemtoReg_id(cur.m2r), .ALUSrc_id(cur.as), .ALUOp_id(cur.op),
        .flush(curFlush),
        .valid_ex(valid_ex), .rs1Addr_ex(rs1Addr_ex), .rs2Addr_ex(rs2Addr_ex), .rdAddr_ex(rdAddr_ex),
        .rs1Data_ex(rs1Data_ex), .rs2Data_ex(rs2Data_ex), .imm_ex(imm_ex), .pc_ex(pc_ex),
        .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex),
        .MemtoReg_ex(MemtoReg_ex), .ALUSrc_ex(ALUSrc_ex), .ALUOp_ex(ALUOp_ex),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int checks = 0;
    int passes = 0;
    instr_t mEx = '0;
    int unsigned mCnt = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic instr_t dutEx();
        instr_t e;
        e = '{v: valid_ex, rs1: rs1Addr_ex, rs2: rs2Addr_ex, rd: rdAddr_ex, u1: 1'b0, u2: 1'b0,
              d1: rs1Data_ex, d2: rs2Data_ex, imm: imm_ex, pc: pc_ex,
              rw: RegWrite_ex, mr: MemRead_ex, mw: MemWrite_ex, m2r: MemtoReg_ex, as: ALUSrc_ex,
              op: ALUOp_ex};
        return e;
    endfunction

    function automatic instr_t mk(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                                  input logic u1, input logic u2, input logic mr);
        instr_t i;
        i.v = 1'b1; i.rs1 = a; i.rs2 = b; i.rd = d; i.u1 = u1; i.u2 = u2;
        i.d1 = $urandom; i.d2 = $urandom; i.imm = $urandom; i.pc = $urandom;
        i.rw = 1'b1; i.mr = mr; i.mw = ~mr & 1'($urandom); i.m2r = mr; i.as = 1'($urandom);
        i.op = 4'($urandom);
        return i;
    endfunction

    // Present one ID instruction for a cycle; the model predicts stall now and EX after the edge.
    task automatic step(input instr_t i, input logic f, output logic s);
        instr_t nx;
        @(negedge clk);
        cur = i;
        curFlush = f;
        s = i.v && !f && mEx.v && mEx.mr && mEx.rd != 0 &&
            ((i.u1 && i.rs1 == mEx.rd) || (i.u2 && i.rs2 == mEx.rd));
        q.push_back('{ex: mEx, stall: s, cnt: CNTW'(mCnt)});
        nx = i; nx.u1 = 1'b0; nx.u2 = 1'b0;
        mEx = (f || s || !i.v) ? '0 : nx;
        if (s && mCnt < (1 << CNTW) - 1) mCnt++;
    endtask

    // Upstream re-presents a stalled instruction until it is accepted.
    task automatic issue(input instr_t i, input logic f);
        logic s;
        for (int k = 0; k < 3; k++) begin
            step(i, f, s);
            if (!s) break;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("ex_regs", dutEx(), e.ex);
                check("stall", stall, e.stall);
                check("stall_cnt", stall_cnt, e.cnt);
            end
        end
    end

    initial begin : driver
        logic s;
        instr_t r;
        #12;
        check("reset_ex", dutEx(), '0);
        check("reset_stall", stall, 1'b0);
        check("reset_cnt", stall_cnt, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) issue(mk(5'(k + 1), 5'(k + 2), 5'(k + 10), 1, 1, 0), 0);
        issue(mk(1, 2, 5, 1, 0, 1), 0);
        issue(mk(5, 7, 6, 1, 1, 0), 0);
        check("cnt_after_loaduse", stall_cnt, 1);
        issue(mk(1, 2, 0, 1, 0, 1), 0);
        issue(mk(0, 1, 6, 1, 1, 0), 0);
        issue(mk(1, 2, 5, 1, 0, 1), 0);
        issue(mk(1, 5, 6, 1, 0, 0), 0);
        issue(mk(1, 2, 5, 1, 0, 1), 0);
        issue(mk(5, 7, 6, 1, 1, 0), 1);
        #2 check("cnt_after_flush", stall_cnt, 1);
        for (int k = 0; k < (1 << CNTW) + 3; k++) begin
            issue(mk(1, 2, 5, 1, 0, 1), 0);
            issue(mk(3, 5, 6, 1, 1, 0), 0);
        end
        #2 check("cnt_saturated", stall_cnt, 15);
        for (int k = 0; k < 300; k++) begin
            r = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0));
            r.v = ($urandom_range(0, 9) != 0);
            issue(r, ($urandom_range(0, 9) == 0));
        end
        issue(mk(1, 2, 5, 1, 0, 1), 0);
        step(mk(5, 7, 6, 1, 1, 0), 0, s);
        #3 check("stall_before_reset", stall, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midreset_ex", dutEx(), '0);
        check("midreset_stall", stall, 1'b0);
        check("midreset_cnt", stall_cnt, 0);
        mEx = '0;
        mCnt = 0;
        @(posedge clk); #2 rst_n = 1'b1;
        issue(mk(8, 9, 10, 1, 1, 0), 0);
        issue(mk(10, 9, 11, 1, 1, 0), 0);
        repeat (2) @(negedge clk);
        #3 check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core, combined with load-use hazard detection.
- Captures decoded operands and control each cycle and presents the EX-stage copies (rs1Addr_ex, rs2Addr_ex, RegWrite_ex, rdAddr_ex, ...) consumed by the forwarding unit and the EX datapath.
- Detects load-use hazards and stalls PC and IF/ID for one cycle while it inserts a bubble.
- Flushes on a taken branch/jump and counts stall cycles for performance analysis.

Parameters:
- XLEN, 32, datapath width of operands, immediate and PC
- CNTW, 16, width of the saturating stall-cycle counter

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- valid_id  input  1  ID holds a real instruction
- rs1Addr_id, rs2Addr_id, rdAddr_id  input  5 each  decoded register addresses
- rs1Used_id, rs2Used_id  input  1 each  instruction actually reads rs1/rs2
- rs1Data_id, rs2Data_id, imm_id, pc_id  input  XLEN each  operands, immediate, PC
- RegWrite_id, MemRead_id, MemWrite_id, MemtoReg_id, ALUSrc_id  input  1 each  decoded control
- ALUOp_id  input  4  ALU operation select
- flush  input  1  taken branch/jump resolved in EX; kill the ID instruction
- valid_ex  output  1  EX holds a real instruction
- rs1Addr_ex, rs2Addr_ex, rdAddr_ex  output  5 each  registered addresses
- rs1Data_ex, rs2Data_ex, imm_ex, pc_ex  output  XLEN each  registered data
- RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, ALUSrc_ex  output  1 each  registered control
- ALUOp_ex  output  4  registered ALU op
- stall  output  1  hold PC and IF/ID this cycle
- stall_cnt  output  CNTW  saturating count of stall cycles

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All *_ex outputs, valid_ex and stall_cnt clear to 0.
  - stall reads 0, since it derives from the cleared registers.
  - Reset asserted mid-stall drops the stall immediately; no pending state survives.
- stall (combinational from registered EX state and current ID inputs):
  - stall = valid_id & ~flush & valid_ex & MemRead_ex & (rdAddr_ex != 0) & ((rs1Used_id & rdAddr_ex == rs1Addr_id) | (rs2Used_id & rdAddr_ex == rs2Addr_id)).
- Register update each rising edge, in priority order:
  1. flush=1: load a bubble.
  2. stall=1: load a bubble. The ID instruction is held upstream and re-presented next cycle.
  3. valid_id=0: load a bubble.
  4. Otherwise: capture all *_id fields into *_ex and set valid_ex=1.
- Bubble: every *_ex field = 0 and valid_ex = 0.
  - rdAddr_ex = 0 and RegWrite_ex = 0 guarantee the forwarding unit never matches a bubble.
  - MemRead_ex = 0 guarantees a stall never exceeds one cycle per load.
- Latency: one cycle from ID inputs to *_ex outputs. No combinational path from any *_id input to any *_ex output.
- flush and a would-be stall in the same cycle: flush wins, stall = 0, bubble loaded, no count.
- rd = x0 load: never stalls.
- Instruction with rs2Used_id = 0 whose rs2 field matches rdAddr_ex: no stall.
- stall_cnt:
  - Increments by 1 on each rising edge where stall = 1.
  - Holds at all-ones (saturates, no wrap).
  - Cleared only by reset.

Test Plan:
- Back-to-back independent ALU ops, valid_id=1, no hazard -> every *_ex equals the previous cycle's *_id, valid_ex=1, stall=0 throughout, stall_cnt=0.
- lw x5 followed by add x6,x5,x7 (rs1Used=1) -> stall=1 for exactly one cycle; bubble in EX (valid_ex=0, rdAddr_ex=0, RegWrite_ex=0); add enters EX the next cycle; stall_cnt=1.
- lw x0 followed by add x6,x0,x1 -> stall=0, no bubble. Separately: lw x5 followed by addi x6,x1,imm whose rs2 field is 5 with rs2Used=0 -> stall=0.
- lw x5 in EX, dependent add in ID, flush=1 in the same cycle -> stall=0, bubble loaded, stall_cnt unchanged.
- Force 2^CNTW + 3 load-use pairs with CNTW=4 -> stall_cnt reaches 15 and holds at 15.
- Assert rst_n=0 asynchronously while stall=1 -> all outputs 0 before the next clock edge, stall=0; after release, the first valid ID instruction appears in EX one cycle later.
